// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: word width and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dmem_pkg;

   localparam int DMEM_WORD_W = 32;

   // IDLE accepts, WAIT burns the extra latency cycles, ACCESS touches the
   // array, RESP holds the response until the datapath takes it.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: one synchronous write port, one registered read port.
// Latency: write commits at the clock edge; read data appears one edge after rd_en.
// Backpressure: none; the read register holds its value until the next rd_en/rd_clr.
// Ports: clk/reset, we/waddr/wdata (write), rd_en/rd_clr/raddr/rdata (read).
// Storage is never reset; only the read register is.
module dmem_array import dmem_pkg::*; #(
   parameter int DEPTH     = 1024,
   parameter int IDX_W     = $clog2(DEPTH),
   parameter     INIT_FILE = ""
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we,
   input  logic [IDX_W-1:0]       waddr,
   input  logic [DMEM_WORD_W-1:0] wdata,
   input  logic                   rd_en,
   input  logic                   rd_clr,
   input  logic [IDX_W-1:0]       raddr,
   output logic [DMEM_WORD_W-1:0] rdata
);

   logic [DMEM_WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // rd_clr lets store / error responses present zero without a read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       rdata <= '0;
      else if (rd_en)  rdata <= mem[raddr];
      else if (rd_clr) rdata <= '0;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave answering lw/sw from the datapath; one transaction in flight.
// Latency: accept at edge T -> rsp_valid high after edge T+LATENCY.
// Backpressure: rsp_ready low holds the response; req_ready stays low until the cycle after the rsp handshake.
// Ports: req_valid/req_ready/req_write/req_addr/req_wdata (request), rsp_valid/rsp_ready/rsp_rdata/rsp_err (response).
// Optional macro DMEM_MISALIGN_ERR_EN: misaligned accesses suppress the store, return 0 and flag rsp_err.
module data_mem_responder import dmem_pkg::*; #(
   parameter int DEPTH     = 1024,
   parameter int ADDR_W    = 32,
   parameter int LATENCY   = 2,
   parameter     INIT_FILE = ""
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DMEM_WORD_W-1:0] req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DMEM_WORD_W-1:0] rsp_rdata,
   output logic                   rsp_err
);

   localparam int IDX_W    = $clog2(DEPTH);
   localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam int CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

   dmem_state_t            state;
   logic [CNT_W-1:0]       cnt;
   logic                   lat_write;
   logic [IDX_W-1:0]       lat_idx;
   logic [DMEM_WORD_W-1:0] lat_wdata;
   logic                   lat_mis;
   logic                   mis_next;
   logic                   arr_we;
   logic                   arr_rd_en;
   logic                   arr_rd_clr;

`ifdef DMEM_MISALIGN_ERR_EN
   assign mis_next = (req_addr[1:0] != 2'b00);
`else
   // Byte offset is dropped: the address is treated as addr>>2.
   assign mis_next = 1'b0;
   logic unused_offset;
   assign unused_offset = ^req_addr[1:0];
`endif

   // Address bits above the word index are ignored, so accesses wrap modulo DEPTH.
   generate
      if (ADDR_W > IDX_W + 2) begin : g_unused_hi
         logic unused_hi;
         assign unused_hi = ^req_addr[ADDR_W-1:IDX_W+2];
      end
   endgenerate

   assign arr_we     = (state == ACCESS) &&  lat_write && !lat_mis;
   assign arr_rd_en  = (state == ACCESS) && !lat_write && !lat_mis;
   assign arr_rd_clr = (state == ACCESS) && !arr_rd_en;

   dmem_array #(
      .DEPTH     (DEPTH),
      .IDX_W     (IDX_W),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk    (clk),
      .reset  (reset),
      .we     (arr_we),
      .waddr  (lat_idx),
      .wdata  (lat_wdata),
      .rd_en  (arr_rd_en),
      .rd_clr (arr_rd_clr),
      .raddr  (lat_idx),
      .rdata  (rsp_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         lat_write <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         lat_mis   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_idx   <= req_addr[IDX_W+1:2];
                  lat_wdata <= req_wdata;
                  lat_mis   <= mis_next;
                  req_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     state <= ACCESS;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_W'(CNT_INIT);
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) state <= ACCESS;
               else           cnt   <= cnt - 1'b1;
            end
            ACCESS: begin
               // Array read/write happens on this edge; response is registered alongside.
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= lat_mis;
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
